// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - direct-mapped BTB with 2-bit counters, ID-stage branch resolution and stats
module branch_predict_unit #(
   parameter int PC_W  = 8,
   parameter int IDX_W = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [PC_W-1:0]  if_pc,
   output logic             pred_taken,
   output logic [PC_W-1:0]  pred_target,
   input  logic             id_branch,
   input  logic             stall,
   input  logic             id_taken,
   input  logic [PC_W-1:0]  id_pc,
   input  logic [31:0]      id_imm,
   input  logic             id_pred_taken,
   input  logic [PC_W-1:0]  id_pred_target,
   output logic             mispredict,
   output logic [PC_W-1:0]  redirect_pc,
   output logic [CNT_W-1:0] stat_branches,
   output logic [CNT_W-1:0] stat_mispredicts
);

   localparam int DEPTH  = 1 << IDX_W;
   localparam int TAG_W  = PC_W - IDX_W - 2;
   localparam int TAG_WS = (TAG_W > 0) ? TAG_W : 1;
   localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

   logic [DEPTH-1:0]  valid_q;
   logic [1:0]        ctr_q    [DEPTH];
   logic [TAG_WS-1:0] tag_q    [DEPTH];
   logic [PC_W-1:0]   target_q [DEPTH];

   logic [IDX_W-1:0]  if_idx;
   logic [IDX_W-1:0]  id_idx;
   logic [TAG_WS-1:0] if_tag;
   logic [TAG_WS-1:0] id_tag;
   logic              if_hit;
   logic              id_hit;
   logic              res;
   logic [PC_W-1:0]   actual_pc;
   logic              unused_bits;

   assign if_idx = if_pc[IDX_W+1:2];
   assign id_idx = id_pc[IDX_W+1:2];

   // With no tag bits left above the index, every valid entry is a hit.
   generate
      if (TAG_W > 0) begin : g_tag
         assign if_tag = if_pc[PC_W-1:IDX_W+2];
         assign id_tag = id_pc[PC_W-1:IDX_W+2];
      end else begin : g_no_tag
         assign if_tag = '0;
         assign id_tag = '0;
      end
   endgenerate

   assign unused_bits = ^{if_pc[1:0], id_pc[1:0], id_imm[31:PC_W]};

   assign if_hit = valid_q[if_idx] && ((TAG_W <= 0) || (tag_q[if_idx] == if_tag));
   assign id_hit = valid_q[id_idx] && ((TAG_W <= 0) || (tag_q[id_idx] == id_tag));

   assign pred_taken  = if_hit && ctr_q[if_idx][1];
   assign pred_target = pred_taken ? target_q[if_idx] : if_pc + PC_STEP;

   assign res         = id_branch && !stall;
   assign actual_pc   = id_taken ? id_pc + id_imm[PC_W-1:0] : id_pc + PC_STEP;
   assign mispredict  = res && ((id_pred_taken != id_taken) ||
                                (id_taken && (id_pred_target != actual_pc)));
   assign redirect_pc = mispredict ? actual_pc : '0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            ctr_q[i] <= 2'b01;
         end
      end else if (res) begin
         if (id_hit) begin
            if (id_taken) begin
               if (ctr_q[id_idx] != 2'b11) ctr_q[id_idx] <= ctr_q[id_idx] + 2'b01;
            end else begin
               if (ctr_q[id_idx] != 2'b00) ctr_q[id_idx] <= ctr_q[id_idx] - 2'b01;
            end
         end else if (id_taken) begin
            valid_q[id_idx] <= 1'b1;
            ctr_q[id_idx]   <= 2'b10;
         end
      end
   end

   // Tags and targets need no reset: valid gates every use of them.
   always_ff @(posedge clk) begin
      if (rst_n && res && id_taken) begin
         target_q[id_idx] <= actual_pc;
         if (!id_hit) tag_q[id_idx] <= id_tag;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_branches    <= '0;
         stat_mispredicts <= '0;
      end else begin
         if (res && (stat_branches != '1))
            stat_branches <= stat_branches + CNT_W'(1);
         if (mispredict && (stat_mispredicts != '1))
            stat_mispredicts <= stat_mispredicts + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_branch_predict_unit.sv
// tb/tb_branch_predict_unit.sv - directed bench for branch_predict_unit with a table-level reference model
module tb_branch_predict_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  if_pc;
   logic        id_branch, stall, id_taken, id_pred_taken;
   logic [7:0]  id_pc, id_pred_target;
   logic [31:0] id_imm;

   logic        pred_taken, mispredict;
   logic [7:0]  pred_target, redirect_pc;
   logic [15:0] stat_branches, stat_mispredicts;

   logic        s_pred_taken, s_mispredict;
   logic [7:0]  s_pred_target, s_redirect_pc;
   logic [1:0]  s_stat_branches, s_stat_mispredicts;

   int vectors = 0;
   int miscompares = 0;

   bit mvalid  [16];
   int mtag    [16];
   int mtarget [16];
   int mctr    [16];
   int mstat_b, mstat_m, mstat_b2, mstat_m2;

   branch_predict_unit dut (
      .clk(clk), .rst_n(rst_n), .if_pc(if_pc),
      .pred_taken(pred_taken), .pred_target(pred_target),
      .id_branch(id_branch), .stall(stall), .id_taken(id_taken),
      .id_pc(id_pc), .id_imm(id_imm), .id_pred_taken(id_pred_taken),
      .id_pred_target(id_pred_target), .mispredict(mispredict),
      .redirect_pc(redirect_pc), .stat_branches(stat_branches),
      .stat_mispredicts(stat_mispredicts)
   );

   branch_predict_unit #(.PC_W(8), .IDX_W(4), .CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .if_pc(if_pc),
      .pred_taken(s_pred_taken), .pred_target(s_pred_target),
      .id_branch(id_branch), .stall(stall), .id_taken(id_taken),
      .id_pc(id_pc), .id_imm(id_imm), .id_pred_taken(id_pred_taken),
      .id_pred_target(id_pred_target), .mispredict(s_mispredict),
      .redirect_pc(s_redirect_pc), .stat_branches(s_stat_branches),
      .stat_mispredicts(s_stat_mispredicts)
   );

   always #5 clk = ~clk;

   function automatic int nidx(input int pc);
      return (pc / 4) % 16;
   endfunction

   function automatic int ntag(input int pc);
      return pc / 64;
   endfunction

   function automatic bit m_pred_taken(input int pc);
      int i;
      i = nidx(pc);
      return mvalid[i] && (mtag[i] == ntag(pc)) && (mctr[i] >= 2);
   endfunction

   function automatic int m_pred_target(input int pc);
      return m_pred_taken(pc) ? mtarget[nidx(pc)] : (pc + 4) % 256;
   endfunction

   function automatic int m_actual();
      logic [31:0] sum;
      sum = id_taken ? 32'(id_pc) + id_imm : 32'(id_pc) + 32'd4;
      return int'(sum % 256);
   endfunction

   function automatic bit m_res();
      return id_branch && !stall;
   endfunction

   function automatic bit m_mis();
      return m_res() && ((id_pred_taken != id_taken) ||
                         (id_taken && (int'(id_pred_target) != m_actual())));
   endfunction

   function automatic int m_redirect();
      return m_mis() ? m_actual() : 0;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: tables updated at each rising edge from the current inputs.
   initial begin : model
      int i;
      int act;
      bit mis;
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            for (int k = 0; k < 16; k++) begin
               mvalid[k] = 1'b0;
               mctr[k]   = 1;
            end
            mstat_b = 0; mstat_m = 0; mstat_b2 = 0; mstat_m2 = 0;
         end else if (m_res()) begin
            i   = nidx(id_pc);
            act = m_actual();
            mis = m_mis();
            if (mvalid[i] && mtag[i] == ntag(id_pc)) begin
               if (id_taken) begin
                  mctr[i]    = (mctr[i] < 3) ? mctr[i] + 1 : 3;
                  mtarget[i] = act;
               end else begin
                  mctr[i] = (mctr[i] > 0) ? mctr[i] - 1 : 0;
               end
            end else if (id_taken) begin
               mvalid[i]  = 1'b1;
               mtag[i]    = ntag(id_pc);
               mtarget[i] = act;
               mctr[i]    = 2;
            end
            mstat_b  = (mstat_b  < 65535) ? mstat_b + 1 : 65535;
            mstat_b2 = (mstat_b2 < 3) ? mstat_b2 + 1 : 3;
            if (mis) begin
               mstat_m  = (mstat_m  < 65535) ? mstat_m + 1 : 65535;
               mstat_m2 = (mstat_m2 < 3) ? mstat_m2 + 1 : 3;
            end
         end
      end
   end

   initial begin : compare
      @(posedge clk);
      forever begin
         @(negedge clk);
         chk("pred_taken",        32'(pred_taken),        32'(m_pred_taken(if_pc)));
         chk("pred_target",       32'(pred_target),       32'(m_pred_target(if_pc)));
         chk("mispredict",        32'(mispredict),        32'(m_mis()));
         chk("redirect_pc",       32'(redirect_pc),       32'(m_redirect()));
         chk("stat_branches",     32'(stat_branches),     32'(mstat_b));
         chk("stat_mispredicts",  32'(stat_mispredicts),  32'(mstat_m));
         chk("s_pred_taken",      32'(s_pred_taken),      32'(m_pred_taken(if_pc)));
         chk("s_pred_target",     32'(s_pred_target),     32'(m_pred_target(if_pc)));
         chk("s_mispredict",      32'(s_mispredict),      32'(m_mis()));
         chk("s_redirect_pc",     32'(s_redirect_pc),     32'(m_redirect()));
         chk("s_stat_branches",   32'(s_stat_branches),   32'(mstat_b2));
         chk("s_stat_mispredicts",32'(s_stat_mispredicts),32'(mstat_m2));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic br, input logic tk, input logic [7:0] pc,
                        input logic [31:0] imm, input logic pt, input logic [7:0] ptg,
                        input logic st);
      id_branch      = br;
      id_taken       = tk;
      id_pc          = pc;
      id_imm         = imm;
      id_pred_taken  = pt;
      id_pred_target = ptg;
      stall          = st;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 8'h00, 1'b0);
   endtask

   initial begin : stim
      rst_n = 1'b0;
      if_pc = 8'h10;
      idle();
      tick();
      tick();
      #3;
      chk("rst_pred_taken", 32'(pred_taken), 32'h0);
      chk("rst_pred_target", 32'(pred_target), 32'h14);
      chk("rst_stat_b", 32'(stat_branches), 32'h0);
      chk("rst_stat_m", 32'(stat_mispredicts), 32'h0);
      chk("rst_mispredict", 32'(mispredict), 32'h0);
      rst_n = 1'b1;

      drive(1'b1, 1'b1, 8'h10, 32'hFFFF_FFF8, 1'b0, 8'h14, 1'b0);
      #3;
      chk("first_mis", 32'(mispredict), 32'h1);
      chk("first_redirect", 32'(redirect_pc), 32'h08);
      tick();
      idle();
      #3;
      chk("alloc_pred_taken", 32'(pred_taken), 32'h1);
      chk("alloc_pred_target", 32'(pred_target), 32'h08);
      chk("alloc_stat_b", 32'(stat_branches), 32'h1);
      chk("alloc_stat_m", 32'(stat_mispredicts), 32'h1);

      repeat (3) begin
         drive(1'b1, 1'b1, 8'h10, 32'hFFFF_FFF8, 1'b1, 8'h08, 1'b0);
         #3;
         chk("correct_taken_mis", 32'(mispredict), 32'h0);
         tick();
      end
      repeat (2) begin
         drive(1'b1, 1'b0, 8'h10, 32'hFFFF_FFF8, 1'b1, 8'h08, 1'b0);
         #3;
         chk("nt_mis", 32'(mispredict), 32'h1);
         chk("nt_redirect", 32'(redirect_pc), 32'h14);
         tick();
      end
      idle();
      #3;
      chk("decay_pred_taken", 32'(pred_taken), 32'h0);
      chk("decay_pred_target", 32'(pred_target), 32'h14);
      chk("decay_stat_b", 32'(stat_branches), 32'd6);

      drive(1'b1, 1'b1, 8'h10, 32'hFFFF_FFF8, 1'b0, 8'h14, 1'b1);
      #3;
      chk("stall_mis", 32'(mispredict), 32'h0);
      chk("stall_redirect", 32'(redirect_pc), 32'h0);
      tick();
      idle();
      #3;
      chk("stall_pred_taken", 32'(pred_taken), 32'h0);
      chk("stall_stat_b", 32'(stat_branches), 32'd6);

      drive(1'b1, 1'b1, 8'hFC, 32'h8, 1'b0, 8'h00, 1'b0);
      #3;
      chk("wrap_taken_redirect", 32'(redirect_pc), 32'h04);
      tick();
      drive(1'b1, 1'b0, 8'hFC, 32'h8, 1'b1, 8'h04, 1'b0);
      #3;
      chk("wrap_nt_mis", 32'(mispredict), 32'h1);
      chk("wrap_nt_redirect", 32'(redirect_pc), 32'h00);
      tick();
      drive(1'b1, 1'b0, 8'hFC, 32'h8, 1'b0, 8'h00, 1'b0);
      #3;
      chk("correct_nt_mis", 32'(mispredict), 32'h0);
      tick();
      drive(1'b1, 1'b1, 8'h10, 32'hFFFF_FFF8, 1'b1, 8'h0C, 1'b0);
      #3;
      chk("bad_target_mis", 32'(mispredict), 32'h1);
      chk("bad_target_redirect", 32'(redirect_pc), 32'h08);
      tick();

      drive(1'b1, 1'b1, 8'h50, 32'h20, 1'b0, 8'h54, 1'b0);
      tick();
      idle();
      #3;
      chk("alias_evict_taken", 32'(pred_taken), 32'h0);
      chk("alias_evict_target", 32'(pred_target), 32'h14);
      if_pc = 8'h50;
      #1;
      chk("alias_new_taken", 32'(pred_taken), 32'h1);
      chk("alias_new_target", 32'(pred_target), 32'h70);
      tick();

      drive(1'b1, 1'b0, 8'h50, 32'h20, 1'b1, 8'h70, 1'b0);
      #3;
      chk("same_cycle_pre", 32'(pred_taken), 32'h1);
      chk("same_cycle_redirect", 32'(redirect_pc), 32'h54);
      tick();
      idle();
      #3;
      chk("same_cycle_post", 32'(pred_taken), 32'h0);

      repeat (5) begin
         drive(1'b1, 1'b1, 8'h20, 32'h4, 1'b0, 8'h24, 1'b0);
         tick();
      end
      idle();
      #3;
      chk("sat_stat_m", 32'(s_stat_mispredicts), 32'd3);
      chk("sat_stat_b", 32'(s_stat_branches), 32'd3);
      chk("wide_stat_m", 32'(stat_mispredicts), 32'd13);
      chk("wide_stat_b", 32'(stat_branches), 32'd17);

      rst_n = 1'b0;
      drive(1'b1, 1'b1, 8'h50, 32'h20, 1'b0, 8'h54, 1'b0);
      tick();
      rst_n = 1'b1;
      idle();
      #3;
      chk("midrst_pred_taken", 32'(pred_taken), 32'h0);
      chk("midrst_pred_target", 32'(pred_target), 32'h54);
      chk("midrst_stat_b", 32'(stat_branches), 32'h0);
      tick();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised successor to the ID-stage branch resolver. Adds a direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters, so IF can predict taken branches.
- Resolves each branch in ID, flags mispredictions with the corrected fetch PC, and trains the tables.
- Sits between the IF PC mux and the IF/ID pipeline register. Keeps saturating branch and mispredict statistics counters.

Parameters:
PC_W, 8, PC width in bits (PC is a byte address; instructions are 4-byte aligned).
IDX_W, 4, BTB index bits; depth = 2**IDX_W entries; index = pc[IDX_W+1:2].
CNT_W, 16, width of the statistics counters.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  synchronous reset, active-low.
if_pc  in  PC_W  current fetch PC.
pred_taken  out  1  IF prediction: taken.
pred_target  out  PC_W  IF predicted next PC.
id_branch  in  1  ID holds a conditional branch/jump to resolve.
stall  in  1  pipeline stall; suppresses resolution and training.
id_taken  in  1  actual branch outcome from ID compare (PCSel).
id_pc  in  PC_W  PC of the instruction in ID.
id_imm  in  32  sign-extended branch offset.
id_pred_taken  in  1  prediction carried with this instruction from IF.
id_pred_target  in  PC_W  predicted next PC carried from IF.
mispredict  out  1  flush IF/ID and redirect fetch.
redirect_pc  out  PC_W  corrected next PC.
stat_branches  out  CNT_W  resolved branch count.
stat_mispredicts  out  CNT_W  mispredict count.

Behaviour:
- Tag = pc[PC_W-1:IDX_W+2]. If that field is empty (PC_W <= IDX_W+2), there is no tag and every valid entry hits.
- Each entry holds: valid, tag, target[PC_W], ctr[1:0].
- Reset (rst_n=0 at a rising edge):
  - all valid=0, all ctr=2'b01, stat counters=0.
  - Tags and targets are don't-care.
  - Outputs during and after reset follow the combinational rules below with the reset state, so pred_taken=0 and pred_target=if_pc+4.
- Lookup (combinational, zero latency):
  - hit = valid[idx] && tag match.
  - pred_taken = hit && ctr[1].
  - pred_target = pred_taken ? target[idx] : if_pc+4, truncated mod 2**PC_W.
- Resolution (combinational):
  - res = id_branch && !stall.
  - actual_pc = id_taken ? id_pc+id_imm[PC_W-1:0] : id_pc+4. All arithmetic is mod 2**PC_W; wrap-around is silent.
  - mispredict = res && (id_pred_taken != id_taken || (id_taken && id_pred_target != actual_pc)).
  - redirect_pc = mispredict ? actual_pc : 0.
- Training (on rising edge when res=1 and rst_n=1), using index/tag from id_pc:
  - hit, taken: ctr++ saturating at 3; target <= actual_pc.
  - hit, not taken: ctr-- saturating at 0; target unchanged.
  - miss, taken: allocate. valid<=1, tag<=id_pc tag, target<=actual_pc, ctr<=2'b10.
  - miss, not taken: no change.
- Same-cycle lookup and training of the same entry: lookup sees the pre-update value. No bypass.
- stall=1: no training, no stat increment, mispredict=0, redirect_pc=0, regardless of id_branch.
- Stats (on rising edge):
  - stat_branches increments when res=1.
  - stat_mispredicts increments when mispredict=1.
  - Both saturate at 2**CNT_W-1. They are registered, so they reflect updates one cycle after the event.
- Reset asserted mid-operation: takes priority over training in the same cycle; tables are cleared.

Test Plan:
- Reset, then if_pc=0x10 -> pred_taken=0, pred_target=0x14. Stats=0; mispredict=0.
- ID branch id_pc=0x10, id_imm=0xFFFFFFF8, id_taken=1, id_pred_taken=0, stall=0 -> mispredict=1, redirect_pc=0x08. Next cycle, if_pc=0x10 gives pred_taken=1, pred_target=0x08, stat_branches=1, stat_mispredicts=1.
- Same branch resolved taken with matching prediction (id_pred_taken=1, id_pred_target=0x08) three more times -> mispredict=0 each time; ctr saturates at 3. Then two not-taken resolutions drop ctr to 1 -> pred_taken=0.
- Repeat the mispredicting case with stall=1 -> mispredict=0, redirect_pc=0; no table or stat change (lookup unchanged next cycle).
- Wrap-around: PC_W=8, id_pc=0xFC, id_imm=8, taken -> redirect_pc=0x04. Not taken at id_pc=0xFC -> actual_pc=0x00.
- Aliasing and saturation: branches at 0x10 and 0x50 (same index, different tag) both taken -> second evicts first; lookup at 0x10 misses. With CNT_W=2, five mispredicts -> stat_mispredicts holds at 3.
